if_id_buf: RTL and testbench

Two-entry instruction buffer between the fetch stage and the decode stage of the npc RV64 pipeline. It accepts fetched (pc, instruction) pairs through a valid/ready handshake, presents the oldest one to decode, and extracts the two source-register addresses for the decode-stage hazard detector. It holds its head entry while that detector requests a stall, and drops all contents on a pipeline flush. A saturating counter records decode stall cycles for performance analysis.

---
 rtl/if_id_buf_pkg.sv | 17 +
 rtl/if_id_buf_inst_fifo2.sv | 79 +++++++
 rtl/if_id_buf.sv | 86 ++++++++
 tb/tb_if_id_buf.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_buf_pkg.sv
// ============================================================================
// Module      : if_id_buf_pkg
// Description : Shared constants for the fetch/decode instruction buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_id_buf_pkg;

  localparam int          REG_ADDR_WIDTH = 5;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;
  localparam int          RS1_LSB        = 15;
  localparam int          RS2_LSB        = 20;

endpackage

`default_nettype wire

// File: rtl/if_id_buf_inst_fifo2.sv
// ============================================================================
// Module      : inst_fifo2
// Description : Two-entry ring of {pc, inst} with flush; flush beats push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fifo2 #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [PC_W-1:0]   wr_pc_i,
  input  logic [INST_W-1:0] wr_inst_i,
  input  logic              rd_en_i,
  output logic [1:0]        count_o,
  output logic [PC_W-1:0]   rd_pc_o,
  output logic [INST_W-1:0] rd_inst_o
);

  logic [PC_W-1:0]   pc_q   [2];
  logic [PC_W-1:0]   pc_d   [2];
  logic [INST_W-1:0] inst_q [2];
  logic [INST_W-1:0] inst_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (wr_en_i) begin
        pc_d[wr_ptr_q]   = wr_pc_i;
        inst_d[wr_ptr_q] = wr_inst_i;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (rd_en_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, wr_en_i} - {1'b0, rd_en_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o   = count_q;
  assign rd_pc_o   = pc_q[rd_ptr_q];
  assign rd_inst_o = inst_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/if_id_buf.sv
// ============================================================================
// Module      : if_id_buf
// Description : IF/ID instruction buffer with NOP fill, rs1/rs2 extraction and
//               a saturating decode-stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [PC_W-1:0]           if_pc,
  input  logic [INST_W-1:0]         if_inst,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      id_valid,
  output logic [PC_W-1:0]           id_pc,
  output logic [INST_W-1:0]         id_inst,
  output logic [REG_ADDR_WIDTH-1:0] id_reg1_raddr,
  output logic [REG_ADDR_WIDTH-1:0] id_reg2_raddr,
  output logic [31:0]               stall_cycles
);

  logic [1:0]        fifo_count;
  logic [PC_W-1:0]   head_pc;
  logic [INST_W-1:0] head_inst;
  logic              push;
  logic              pop;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  // Ready comes only from the registered occupancy so fetch never sees a
  // combinational path from the hazard detector or the redirect.
  assign if_ready = (fifo_count != 2'(DEPTH));
  assign id_valid = (fifo_count != 2'd0);
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & ~stall;

  inst_fifo2 #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .wr_en_i   (push),
    .wr_pc_i   (if_pc),
    .wr_inst_i (if_inst),
    .rd_en_i   (pop),
    .count_o   (fifo_count),
    .rd_pc_o   (head_pc),
    .rd_inst_o (head_inst)
  );

  assign id_pc         = id_valid ? head_pc : '0;
  assign id_inst       = id_valid ? head_inst : INST_W'(INST_NOP);
  assign id_reg1_raddr = id_inst[RS1_LSB +: REG_ADDR_WIDTH];
  assign id_reg2_raddr = id_inst[RS2_LSB +: REG_ADDR_WIDTH];

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_buf.sv
// ============================================================================
// Module      : tb_if_id_buf
// Description : Self-checking bench for if_id_buf against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic [4:0]  id_reg1_raddr;
  logic [4:0]  id_reg2_raddr;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  if_id_buf #(.DEPTH(2), .PC_W(64), .INST_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .stall         (stall),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_reg1_raddr (id_reg1_raddr),
    .id_reg2_raddr (id_reg2_raddr),
    .stall_cycles  (stall_cycles)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mstall;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] ei;
    logic [63:0] ep;
    bit          ev;
    ev = (mq.size() != 0);
    ei = ev ? mq[0].inst : 32'h0000_0013;
    ep = ev ? mq[0].pc : 64'd0;
    chk("if_ready", {63'd0, if_ready}, {63'd0, mq.size() < 2});
    chk("id_valid", {63'd0, id_valid}, {63'd0, ev});
    chk("id_pc", id_pc, ep);
    chk("id_inst", {32'd0, id_inst}, {32'd0, ei});
    chk("reg1", {59'd0, id_reg1_raddr}, {59'd0, ei[19:15]});
    chk("reg2", {59'd0, id_reg2_raddr}, {59'd0, ei[24:20]});
    chk("stall_cycles", {32'd0, stall_cycles}, {32'd0, mstall});
  endtask

  // Called at a falling edge: drives inputs, lets one rising edge pass, updates
  // the model and compares at the next falling edge.
  task automatic step(input bit v, input logic [63:0] pc, input logic [31:0] inst,
                      input bit st, input bit fl);
    bit rdy, val;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    stall    = st;
    flush    = fl;
    rdy = (mq.size() < 2);
    val = (mq.size() != 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (val && !st) void'(mq.pop_front());
      if (v && rdy) mq.push_back('{pc: pc, inst: inst});
    end
    if (val && st && !fl && mstall != 32'hFFFF_FFFF) mstall++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] base;
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_inst = '0; stall = 1'b0; flush = 1'b0;
    mstall = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare_all();
    chk("rst_inst", {32'd0, id_inst}, 64'h13);
    chk("rst_ready", {63'd0, if_ready}, 64'd1);

    // Single push then pop
    step(1'b1, 64'h8000_0000, 32'h00A5_0533, 1'b0, 1'b0);
    chk("single_valid", {63'd0, id_valid}, 64'd1);
    chk("single_rs1", {59'd0, id_reg1_raddr}, 64'd10);
    chk("single_rs2", {59'd0, id_reg2_raddr}, 64'd10);
    step(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
    chk("single_popped", {63'd0, id_valid}, 64'd0);
    chk("single_nop", {32'd0, id_inst}, 64'h13);

    // Stall fills the buffer
    base = mstall;
    step(1'b1, 64'h100, 32'h0010_8093, 1'b1, 1'b0);
    step(1'b1, 64'h104, 32'h0021_0113, 1'b1, 1'b0);
    chk("stall_full_ready", {63'd0, if_ready}, 64'd0);
    chk("stall_head_pc", id_pc, 64'h100);
    step(1'b1, 64'h108, 32'h0031_8193, 1'b1, 1'b0);
    chk("stall_count", {32'd0, stall_cycles}, {32'd0, base + 32'd2});
    chk("stall_hold_pc", id_pc, 64'h100);
    step(1'b1, 64'h108, 32'h0031_8193, 1'b0, 1'b0);
    chk("release_pc1", id_pc, 64'h104);
    step(1'b1, 64'h108, 32'h0031_8193, 1'b0, 1'b0);
    chk("release_pc2", id_pc, 64'h108);
    idle(1);
    chk("release_empty", {63'd0, id_valid}, 64'd0);

    // Flush with same-cycle push (full and single-entry cases)
    step(1'b1, 64'h200, 32'h0000_0033, 1'b1, 1'b0);
    step(1'b1, 64'h204, 32'h0000_0033, 1'b1, 1'b0);
    step(1'b1, 64'h208, 32'h0000_0033, 1'b0, 1'b1);
    chk("flush_valid", {63'd0, id_valid}, 64'd0);
    step(1'b1, 64'h300, 32'h0000_0033, 1'b1, 1'b0);
    step(1'b1, 64'h304, 32'h0000_0033, 1'b0, 1'b1);
    chk("flush_drop_push", {63'd0, id_valid}, 64'd0);
    chk("flush_ready", {63'd0, if_ready}, 64'd1);
    step(1'b1, 64'h400, 32'h0000_0033, 1'b0, 1'b0);
    chk("post_flush_push", id_pc, 64'h400);

    // Push/pop concurrency at count 1
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 64'h400 + 64'(4 * i), 32'h0000_0033, 1'b0, 1'b0);
      chk("conc_ready", {63'd0, if_ready}, 64'd1);
      chk("conc_pc", id_pc, 64'h400 + 64'(4 * i));
    end
    idle(1);

    // Saturation
    step(1'b1, 64'h500, 32'h0000_0033, 1'b1, 1'b0);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    mstall = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
      chk("sat_value", {32'd0, stall_cycles}, 64'hFFFF_FFFF);
    end
    step(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);

    // Async reset while full
    step(1'b1, 64'h600, 32'h00C5_8593, 1'b1, 1'b0);
    step(1'b1, 64'h604, 32'h00C5_8593, 1'b1, 1'b0);
    if_valid = 1'b0; stall = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, id_valid}, 64'd0);
    chk("arst_ready", {63'd0, if_ready}, 64'd1);
    chk("arst_pc", id_pc, 64'd0);
    chk("arst_inst", {32'd0, id_inst}, 64'h13);
    chk("arst_rs1", {59'd0, id_reg1_raddr}, 64'd0);
    chk("arst_stall", {32'd0, stall_cycles}, 64'd0);
    mq.delete();
    mstall = 32'd0;
    #1;
    rst = 1'b0;
    @(negedge clk);
    compare_all();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom,
           $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
